// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and helpers for the UART baud-tick generator.
package uart_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    localparam int OVS_DEF    = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v)
                r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/baud_tick_chan.sv
// baud_tick_chan: one fractional baud channel producing an oversample tick and a bit tick.
module baud_tick_chan
    import uart_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FRAC_W     = FRAC_W_DEF,
    parameter int OVS        = OVS_DEF,
    parameter bit HALF_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              en,
    input  logic              restart,
    output logic              os_tick,
    output logic              bit_tick
);

    localparam int PRE_W = clog2(OVS);
    localparam logic [PRE_W-1:0] PRE_INIT = HALF_FIRST ? PRE_W'(OVS / 2) : '0;

    logic [CNT_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [PRE_W-1:0]  pre;
    logic              active;
    logic              run;
    logic              resync;
    logic              wrap;
    logic [FRAC_W:0]   sum;

    assign run    = en && (div_int != '0);
    // A channel coming out of stall (enable, nonzero divisor or reset) resynchronises like a restart.
    assign resync = restart || !active;
    assign sum    = {1'b0, acc} + {1'b0, div_frac};
    assign wrap   = pre == PRE_W'(OVS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            pre      <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end else if (!run) begin
            active   <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            pre      <= PRE_INIT;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end else if (resync) begin
            active   <= 1'b1;
            cnt      <= div_int - CNT_W'(1);
            acc      <= '0;
            pre      <= PRE_INIT;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end else if (cnt == '0) begin
            // Carry out of the fractional sum stretches this period by one cycle.
            cnt      <= sum[FRAC_W] ? div_int : div_int - CNT_W'(1);
            acc      <= sum[FRAC_W-1:0];
            pre      <= pre + PRE_W'(1);
            os_tick  <= 1'b1;
            bit_tick <= wrap;
        end else begin
            cnt      <= cnt - CNT_W'(1);
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: independent RX and TX fractional baud-tick channels.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int OVS     = OVS_DEF,
    parameter bit RX_HALF = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  div_int_rx,
    input  logic [FRAC_W-1:0] div_frac_rx,
    input  logic [CNT_W-1:0]  div_int_tx,
    input  logic [FRAC_W-1:0] div_frac_tx,
    input  logic              en_rx,
    input  logic              en_tx,
    input  logic              restart_rx,
    input  logic              restart_tx,
    output logic              rx_os_tick,
    output logic              rx_bit_tick,
    output logic              tx_os_tick,
    output logic              tx_bit_tick
);

    baud_tick_chan #(
        .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS), .HALF_FIRST(RX_HALF)
    ) u_rx (
        .clk(clk), .rst_n(rst_n), .div_int(div_int_rx), .div_frac(div_frac_rx),
        .en(en_rx), .restart(restart_rx), .os_tick(rx_os_tick), .bit_tick(rx_bit_tick)
    );

    baud_tick_chan #(
        .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS), .HALF_FIRST(1'b0)
    ) u_tx (
        .clk(clk), .rst_n(rst_n), .div_int(div_int_tx), .div_frac(div_frac_tx),
        .en(en_tx), .restart(restart_tx), .os_tick(tx_os_tick), .bit_tick(tx_bit_tick)
    );

endmodule
